// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches words over req/ack and hands them
// to the decoder under valid/ready; next PC comes from jump/branch/zero on accept.
module instr_fetch #(
    parameter logic [31:0] PC_RESET    = 32'h0000_3000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] icount,
    output logic        fetch_err
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_ERR} state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_icount;
    logic [7:0]  r_tmo;
    logic        r_req;
    logic        r_valid;
    logic        r_err;

    logic [31:0] w_pc4;
    logic [31:0] w_boff;
    logic [31:0] w_npc;

    assign w_pc4  = r_pc + 32'd4;
    assign w_boff = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    // jump outranks branch when the decoder raises both
    assign w_npc  = jump            ? {w_pc4[31:28], r_instr[25:0], 2'b00} :
                    (branch && zero) ? w_pc4 + w_boff : w_pc4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pc     <= PC_RESET;
            r_instr  <= '0;
            r_icount <= '0;
            r_tmo    <= '0;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pc[1:0] != 2'b00) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                        r_req   <= 1'b1;
                        r_tmo   <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= S_HOLD;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end else if (r_tmo == TMO_LAST) begin
                        r_state <= S_ERR;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        r_icount <= r_icount + 32'd1;
                        r_pc     <= w_npc;
                        r_valid  <= 1'b0;
                        // a misaligned target never gets a request on the bus
                        if (w_npc[1:0] != 2'b00) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            r_req   <= 1'b1;
                            r_tmo   <= '0;
                        end
                    end
                end
                S_ERR: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_err   <= 1'b1;
                end
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign funct       = r_instr[5:0];
    assign instr_valid = r_valid;
    assign icount      = r_icount;
    assign fetch_err   = r_err;
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-issue MIPS core. It sits in front of the control decoder. It holds the PC, fetches instruction words from instruction memory over a req/ack handshake, and presents the word with its `opcode`/`funct` fields under a valid/ready handshake. It computes the next PC from the decoder's `jump`/`Branch` outputs and the ALU zero flag. There is no delay slot.

## Interface
- `PC_RESET`, default 32'h0000_3000: PC value loaded by reset.
- `ACK_TIMEOUT`, default 16: maximum cycles to wait for `imem_ack` before error; legal range 1..255.
- `clk  in  1`: clock; all state changes on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `imem_req  out  1`: fetch request to instruction memory.
- `imem_addr  out  32`: byte address of the fetch; equals `pc`.
- `imem_ack  in  1`: memory has `imem_rdata` valid this cycle.
- `imem_rdata  in  32`: instruction word.
- `instr  out  32`: held instruction word.
- `opcode  out  6`: `instr[31:26]`.
- `funct  out  6`: `instr[5:0]`.
- `pc  out  32`: address of the current or held instruction.
- `instr_valid  out  1`: `instr` is valid for the decoder and datapath.
- `instr_ready  in  1`: the datapath completes the held instruction this cycle.
- `jump  in  1`: decoder jump, sampled only on accept.
- `branch  in  1`: decoder Branch, sampled only on accept.
- `zero  in  1`: ALU zero flag, sampled only on accept.
- `icount  out  32`: number of accepted instructions; wraps modulo 2^32.
- `fetch_err  out  1`: sticky error flag.

## Operation
- FSM states and transitions:
  - IDLE → FETCH, one cycle after reset release.
  - FETCH → HOLD when `imem_ack`=1.
  - FETCH → ERR when the timeout count reaches `ACK_TIMEOUT` without an ack.
  - HOLD → FETCH when `instr_ready`=1.
  - ERR is terminal; only reset leaves it.
- Entering FETCH with `pc[1:0]`≠0 goes to ERR instead; no request is issued.
- `imem_req`=1 only in FETCH. `imem_addr`=`pc` at all times.
- In FETCH, on `imem_ack`=1: `instr` ← `imem_rdata`. `imem_ack` in any other state is ignored, and `instr` is unchanged.
- `instr_valid`=1 only in HOLD. `instr`, `opcode` and `funct` stay stable throughout HOLD.
- Accept is `instr_valid && instr_ready`. On accept:
  - `icount` ← `icount`+1.
  - If `jump`: `pc` ← {`pc4[31:28]`, `instr[25:0]`, 2'b00}.
  - Else if `branch && zero`: `pc` ← `pc4` + (sign-extended `instr[15:0]` << 2).
  - Else: `pc` ← `pc4`.
  - `pc4` = `pc`+4. All address arithmetic is 32-bit modulo 2^32; `pc` wraps from 32'hFFFF_FFFC to 0.
  - `jump` has priority over `branch` when both are 1.
- Timeout counter:
  - Cleared on entering FETCH.
  - Increments on each FETCH cycle without an ack.
  - In the cycle where the counter = `ACK_TIMEOUT`-1 with no ack, the FSM moves to ERR.
  - An ack in that same cycle wins: the FSM goes to HOLD.
- In ERR: `fetch_err`=1, `imem_req`=0, `instr_valid`=0, and `pc`/`icount` are frozen.

## Timing
- Reset (`rst`=0), applied immediately and asynchronously:
  - state IDLE, `pc`=`PC_RESET`, `instr`=0, `icount`=0.
  - `imem_req`=0, `instr_valid`=0, `fetch_err`=0, timeout count 0.
- Reset asserted mid-fetch or mid-hold aborts with no accept and no `icount` increment.
- The first `imem_req` is high in the second rising-edge cycle after `rst` deasserts: IDLE lasts one cycle.
- With a zero-wait memory (ack in the same cycle as req) and `instr_ready` tied to 1, there is one instruction per 2 cycles: FETCH, HOLD, FETCH, and so on.
- `instr_valid` rises in the cycle after the ack edge. The new `pc` is visible on `imem_addr` in the cycle after accept.
- `instr_ready` while `instr_valid`=0 has no effect.

## Test plan
- Reset and sequential fetch:
  - Stimulus: release reset, zero-wait memory returning 32'h0000_0021 (addu), `instr_ready`=1.
  - Required: `imem_addr` = 0x3000, 0x3004, 0x3008; `opcode`=0 and `funct`=0x21 in each HOLD; `icount`=3 after 3 accepts.
- Branch taken and not taken:
  - Stimulus: beq 32'h1000_FFFF at 0x3010 accepted with `branch`=1.
  - Required: with `zero`=1, next addr is 0x3010; with `zero`=0, next addr is 0x3014.
- Jump with priority:
  - Stimulus: 32'h0800_0C10 at 0x3020 accepted with `jump`=1 and `branch`=`zero`=1.
  - Required: next addr is 0x0000_3040.
- Backpressure and wait states:
  - Stimulus: ack delayed 3 cycles, then `instr_ready` held 0 for 5 cycles.
  - Required: `imem_req` stays high for 4 cycles; `instr`/`pc` are stable for 5 HOLD cycles; no fetch occurs until accept.
- Timeout and misalignment:
  - Stimulus: `ACK_TIMEOUT`=4 with no ack.
  - Required: `fetch_err`=1 after 4 FETCH cycles, `imem_req`=0 thereafter, and stays sticky until reset.
  - Stimulus: `PC_RESET`=32'h3002.
  - Required: ERR with no `imem_req` ever asserted.
- Mid-operation reset:
  - Stimulus: assert `rst`=0 during HOLD at `pc`=0x3008 with `icount`=2.
  - Required: outputs return to reset values immediately, without waiting for a clock edge.
